vga_fb_scanout: RTL and testbench

VGA_FB_SCANOUT -- requirements
Module: vga_fb_scanout

---
 rtl/vga_fb_scanout_if.sv | 13 +
 rtl/vga_fb_scanout.sv | 159 +++++++++++++++
 tb/tb_vga_fb_scanout.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_fb_scanout_if.sv
// Pixel write port and buffer-swap handshake of vga_fb_scanout.
// The drawing client is the master; the scanout block is the slave.
interface vga_fb_scanout_if;
  logic [9:0] x;
  logic [9:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       swap_req;
  logic       swap_ack;

  modport master (output x, y, colour, plot, swap_req, input  swap_ack);
  modport slave  (input  x, y, colour, plot, swap_req, output swap_ack);
endinterface

// File: rtl/vga_fb_scanout.sv
// 3-bit colour framebuffer with VGA timing generator and 2-stage scanout pipeline.
// Define VGA_FB_DOUBLE_BUFFER_EN for front/back buffers swapped at frame_tick.
module vga_fb_scanout #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic             clk,
  input  logic             resetn,
  vga_fb_scanout_if.slave  wr,
  output logic             frame_tick,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             vga_blank_n,
  output logic [7:0]       vga_r,
  output logic [7:0]       vga_g,
  output logic [7:0]       vga_b
);

  localparam int H_TOTAL  = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_RES + V_FP + V_SYNC + V_BP;
  localparam int FB_WORDS = H_RES * V_RES;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_RES);
  localparam logic [9:0] V_VIS    = 10'(V_RES);
  localparam logic [9:0] HS_START = 10'(H_RES + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_RES + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_RES + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_RES + V_FP + V_SYNC);

  logic [9:0] hc;
  logic [9:0] vc;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == H_LAST) begin
      hc <= '0;
      vc <= (vc == V_LAST) ? '0 : vc + 10'd1;
    end else begin
      hc <= hc + 10'd1;
    end
  end

  logic visible;
  logic hs_raw;
  logic vs_raw;

  assign visible    = (hc < H_VIS) && (vc < V_VIS);
  assign hs_raw     = !((hc >= HS_START) && (hc < HS_END));
  assign vs_raw     = !((vc >= VS_START) && (vc < VS_END));
  assign frame_tick = (hc == '0) && (vc == V_VIS);

  logic        wr_en;
  logic [18:0] wr_addr;

  assign wr_en   = wr.plot && (wr.x < H_VIS) && (wr.y < V_VIS);
  assign wr_addr = 19'(wr.y) * 19'(H_RES) + 19'(wr.x);

  // Stage 1: scan address and raw timing. Address is parked at 0 in blanking to stay in range.
  logic [18:0] rd_addr;
  logic        hs_d1, vs_d1, blank_d1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_addr  <= '0;
      hs_d1    <= 1'b1;
      vs_d1    <= 1'b1;
      blank_d1 <= 1'b0;
    end else begin
      rd_addr  <= visible ? 19'(vc) * 19'(H_RES) + 19'(hc) : '0;
      hs_d1    <= hs_raw;
      vs_d1    <= vs_raw;
      blank_d1 <= visible;
    end
  end

  logic [2:0] rd_data;

`ifdef VGA_FB_DOUBLE_BUFFER_EN
  logic front;
  logic swap_pending;
  logic rd_buf;

  // A request landing on a frame_tick that already swaps stays pending for the next frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      front        <= 1'b0;
      swap_pending <= 1'b0;
      rd_buf       <= 1'b0;
    end else begin
      rd_buf <= front;
      if (frame_tick && swap_pending) begin
        front        <= !front;
        swap_pending <= wr.swap_req;
      end else if (wr.swap_req) begin
        swap_pending <= 1'b1;
      end
    end
  end

  assign wr.swap_ack = frame_tick && swap_pending;

  logic [2:0] mem0 [FB_WORDS];
  logic [2:0] mem1 [FB_WORDS];

  // NOTE: framebuffer RAM has no reset; contents survive resetn so the RAMs infer as block memory.
  always_ff @(posedge clk) begin
    if (wr_en && front)  mem0[wr_addr] <= wr.colour;
    if (wr_en && !front) mem1[wr_addr] <= wr.colour;
    rd_data <= rd_buf ? mem1[rd_addr] : mem0[rd_addr];
  end
`else
  logic unused_swap_req;

  assign unused_swap_req = wr.swap_req;
  assign wr.swap_ack     = 1'b0;

  logic [2:0] mem [FB_WORDS];

  // NOTE: framebuffer RAM has no reset; contents survive resetn so the RAM infers as block memory.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr.colour;
    rd_data <= mem[rd_addr];
  end
`endif

  // Stage 2: timing delayed to line up with rd_data.
  logic hs_d2, vs_d2, blank_d2;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hs_d2    <= 1'b1;
      vs_d2    <= 1'b1;
      blank_d2 <= 1'b0;
    end else begin
      hs_d2    <= hs_d1;
      vs_d2    <= vs_d1;
      blank_d2 <= blank_d1;
    end
  end

  assign vga_hs      = hs_d2;
  assign vga_vs      = vs_d2;
  assign vga_blank_n = blank_d2;
  assign vga_r       = (blank_d2 && rd_data[2]) ? 8'hFF : 8'h00;
  assign vga_g       = (blank_d2 && rd_data[1]) ? 8'hFF : 8'h00;
  assign vga_b       = (blank_d2 && rd_data[0]) ? 8'hFF : 8'h00;

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Self-checking bench for vga_fb_scanout on a shrunken raster (24x17 total, 16x12 visible).
// A frame-level model (pixel position from cycle count, framebuffer array) predicts every output.
module tb_vga_fb_scanout;

  localparam int H_RES  = 16;
  localparam int V_RES  = 12;
  localparam int H_FP   = 2;
  localparam int H_SYNC = 3;
  localparam int H_BP   = 3;
  localparam int V_FP   = 1;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 2;
  localparam int HT     = H_RES + H_FP + H_SYNC + H_BP;
  localparam int VT     = V_RES + V_FP + V_SYNC + V_BP;
  localparam int F      = HT * VT;
  localparam int NPIX   = H_RES * V_RES;
  localparam int TICK_Q = V_RES * HT;
`ifdef VGA_FB_DOUBLE_BUFFER_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn;
  logic       frame_tick, vga_hs, vga_vs, vga_blank_n;
  logic [7:0] vga_r, vga_g, vga_b;

  vga_fb_scanout_if bus ();

  vga_fb_scanout #(
    .H_RES(H_RES), .V_RES(V_RES), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk(clk), .resetn(resetn), .wr(bus), .frame_tick(frame_tick),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: framebuffers (-1 = never written), cycle index since reset release, swap state.
  int          fb [2][NPIX];
  int          k;
  bit          front, pending;
  logic [26:0] exp_vec;
  bit          exp_known;

  typedef struct {
    int          x;
    int          y;
    int          colour;
    int          px;
    int          py;
    logic [23:0] rgb;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, k);
    end
  endtask

  // Expected {hs, vs, blank_n, rgb} for raster position p (p < 0: pipeline still empty).
  function automatic logic [26:0] expect_at(input int p, output bit known);
    int q, h, v, c;
    logic hs, vs, bl;
    logic [23:0] rgb;
    known = 1'b1;
    if (p < 0) return {3'b110, 24'h0};
    q   = p % F;
    h   = q % HT;
    v   = q / HT;
    hs  = !(h >= H_RES + H_FP && h < H_RES + H_FP + H_SYNC);
    vs  = !(v >= V_RES + V_FP && v < V_RES + V_FP + V_SYNC);
    bl  = (h < H_RES) && (v < V_RES);
    rgb = '0;
    if (bl) begin
      c = fb[front][v * H_RES + h];
      if (c < 0) known = 1'b0;
      else rgb = {c[2] ? 8'hFF : 8'h00, c[1] ? 8'hFF : 8'h00, c[0] ? 8'hFF : 8'h00};
    end
    return {hs, vs, bl, rgb};
  endfunction

  // Drive one cycle, advance the model at the edge, compare every output at the falling edge.
  task automatic cycle(input bit pl, input int px, input int py, input int pc, input bit sw);
    bit ft;
    int wb;
    logic [28:0] act, expv;
    bus.plot     = pl;
    bus.x        = 10'(px);
    bus.y        = 10'(py);
    bus.colour   = 3'(pc);
    bus.swap_req = sw;
    @(posedge clk);
    exp_vec = expect_at(k - 1, exp_known);
    ft      = (k % F) == TICK_Q;
    wb      = (DBL && !front) ? 1 : 0;
    if (pl && px < H_RES && py < V_RES) fb[wb][py * H_RES + px] = pc;
    if (DBL) begin
      if (ft && pending) begin
        front   = !front;
        pending = sw;
      end else if (sw) begin
        pending = 1'b1;
      end
    end
    k++;
    @(negedge clk);
    ft   = (k % F) == TICK_Q;
    act  = {vga_hs, vga_vs, vga_blank_n,
            exp_known ? {vga_r, vga_g, vga_b} : 24'h0, frame_tick, bus.swap_ack};
    expv = {exp_vec, ft, ft && pending};
    check("scan", 32'(act), 32'(expv));
  endtask

  task automatic idle();
    cycle(1'b0, 0, 0, 0, 1'b0);
  endtask

  // Idle until the cycle about to be driven sits at frame offset m.
  task automatic idle_until(input int m);
    for (int i = 0; i < F && (k % F) != m; i++) idle();
  endtask

  task automatic fill(input bit solid, input int colour);
    for (int i = 0; i < NPIX; i++)
      cycle(1'b1, i % H_RES, i / H_RES, solid ? colour : (i * 5 + 3) % 8, 1'b0);
  endtask

  task automatic wait_ack(input string name, output int cycles);
    bit found = 1'b0;
    cycles = 0;
    for (int i = 0; i < 3 * F && !found; i++) begin
      idle();
      cycles++;
      if (bus.swap_ack === 1'b1) found = 1'b1;
    end
    check(name, 32'(found), 32'd1);
  endtask

  task automatic reset_midline();
    #2 resetn = 1'b0;
    #1 check("reset_async_outputs",
             32'({vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b, frame_tick, bus.swap_ack}),
             32'({3'b110, 24'h0, 2'b00}));
    k = 0;
    front = 1'b0;
    pending = 1'b0;
    bus.plot = 1'b0;
    bus.swap_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    int hs_low, vs_low, bl_high, ticks, green, dly;
    bit found;

    vecs[0] = '{0,    11,   1, 0,  11, 24'h0000FF};
    vecs[1] = '{16,   10,   7, 0,  11, 24'h0000FF};
    vecs[2] = '{0,    0,    4, 0,  0,  24'hFF0000};
    vecs[3] = '{15,   11,   3, 15, 11, 24'h00FFFF};
    vecs[4] = '{5,    12,   6, 15, 11, 24'h00FFFF};
    vecs[5] = '{1023, 1023, 7, 15, 11, 24'h00FFFF};
    vecs[6] = '{7,    3,    2, 7,  3,  24'h00FF00};

    foreach (fb[b, i]) fb[b][i] = -1;
    k = 0;
    front = 1'b0;
    pending = 1'b0;
    resetn = 1'b0;
    bus.plot = 1'b0;
    bus.x = '0;
    bus.y = '0;
    bus.colour = '0;
    bus.swap_req = 1'b0;
    #12;
    check("reset_state",
          32'({vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b, frame_tick, bus.swap_ack}),
          32'({3'b110, 24'h0, 2'b00}));
    @(negedge clk);
    resetn = 1'b1;

    fill(1'b0, 0);
    if (DBL) begin
      cycle(1'b0, 0, 0, 0, 1'b1);
      wait_ack("init_swap_ack", dly);
      fill(1'b0, 0);
    end

    // One full frame of delayed outputs: sync widths, visible area, single frame_tick.
    idle_until(1);
    hs_low = 0; vs_low = 0; bl_high = 0; ticks = 0;
    for (int i = 0; i < F; i++) begin
      idle();
      if (!vga_hs) hs_low++;
      if (!vga_vs) vs_low++;
      if (vga_blank_n) bl_high++;
      if (frame_tick) ticks++;
    end
    check("frame_tick_count", 32'(ticks), 32'd1);
    check("hs_low_cycles", 32'(hs_low), 32'(H_SYNC * VT));
    check("vs_low_cycles", 32'(vs_low), 32'(V_SYNC * HT));
    check("blank_n_high_cycles", 32'(bl_high), 32'(NPIX));

`ifndef VGA_FB_DOUBLE_BUFFER_EN
    // Table: plot, then look at a chosen pixel the next time it is scanned out.
    foreach (vecs[i]) begin
      cycle(1'b1, vecs[i].x, vecs[i].y, vecs[i].colour, 1'b0);
      found = 1'b0;
      for (int j = 0; j < 2 * F && !found; j++) begin
        idle();
        if (((k - 2) % F) == vecs[i].py * HT + vecs[i].px) found = 1'b1;
      end
      check($sformatf("vec%0d_reached", i), 32'(found), 32'd1);
      check($sformatf("vec%0d_rgb", i), 32'({vga_r, vga_g, vga_b}), 32'(vecs[i].rgb));
    end

    // Write (0,0) on the very edge that scanout reads it: old colour now, new colour next frame.
    idle_until(1);
    cycle(1'b1, 0, 0, 1, 1'b0);
    check("rdw_same_frame_old", 32'({vga_r, vga_g, vga_b}), 32'h00FF0000);
    idle_until(1);
    idle();
    check("rdw_next_frame_new", 32'({vga_r, vga_g, vga_b}), 32'h000000FF);
`else
    // Fill back buffer green, request swap mid-frame, expect ack on the next frame_tick.
    fill(1'b1, 2);
    idle_until(3 * HT + 5);
    cycle(1'b0, 0, 0, 0, 1'b1);
    wait_ack("swap_ack_seen", dly);
    check("swap_ack_with_frame_tick", 32'(frame_tick), 32'd1);
    idle_until(1);
    green = 0;
    for (int i = 0; i < F; i++) begin
      idle();
      if (vga_blank_n && {vga_r, vga_g, vga_b} == 24'h00FF00) green++;
    end
    check("green_frame_pixels", 32'(green), 32'(NPIX));

    // Request on the frame_tick cycle itself: swap one full frame later.
    idle_until(TICK_Q);
    cycle(1'b0, 0, 0, 0, 1'b1);
    check("no_ack_on_request_tick", 32'(bus.swap_ack), 32'd0);
    wait_ack("late_swap_ack_seen", dly);
    check("late_swap_delay", 32'(dly), 32'(F - 1));
`endif

    // Random plots (in and out of range) and occasional swap requests.
    for (int i = 0; i < 3 * F; i++)
      cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, H_RES + 2)),
            int'($urandom_range(0, V_RES + 2)), int'($urandom_range(0, 7)),
            $urandom_range(0, 59) == 0);
    repeat (F) idle();

    // Mid-line reset in the visible area; timing restarts, framebuffer kept.
    idle_until(5 * HT + 10);
    reset_midline();
    idle();
    check("release_cycle1_blank", 32'(vga_blank_n), 32'd0);
    idle();
    check("release_cycle2_blank", 32'(vga_blank_n), 32'd1);
    repeat (F + 4) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
